// File: rtl/axum_ctx_dma_pkg.sv
// ============================================================================
// Module  : axum_ctx_dma_pkg
// Brief   : Shared types and constants for the context save/restore engine.
// Revision: 1.0
// ============================================================================
`default_nettype none

package axum_ctx_dma_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RF_REQ   = 3'd1,
        RF_WAIT  = 3'd2,
        MEM_REQ  = 3'd3,
        MEM_WAIT = 3'd4,
        DONE     = 3'd5
    } ctx_dma_state_e;

    localparam int unsigned CtxDmaLastReg  = 31;
    localparam int unsigned CtxDmaLastRegE = 15;

endpackage

`default_nettype wire

// File: rtl/axum_ctx_dma.sv
// ============================================================================
// Module  : axum_ctx_dma
// Brief   : Copies the inactive register context to/from a memory buffer,
//           one register-map access and one data-bus access per register.
// Revision: 1.0
// ============================================================================
`default_nettype none

module axum_ctx_dma
    import axum_ctx_dma_pkg::*;
#(
    parameter bit                      RV32E        = 1'b0,
    parameter int unsigned             DataWidth    = 32,
    parameter int unsigned             AddressWidth = 32,
    parameter logic [AddressWidth-1:0] RfMapBase    = '0
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    input  logic                      dir_i,
    input  logic [AddressWidth-1:0]   mem_base_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic                      rf_map_req_o,
    output logic [AddressWidth-1:0]   rf_map_addr_o,
    output logic                      rf_map_we_o,
    output logic [DataWidth/8-1:0]    rf_map_be_o,
    output logic [DataWidth-1:0]      rf_map_wdata_o,
    input  logic                      rf_map_rvalid_i,
    input  logic [DataWidth-1:0]      rf_map_rdata_i,
    input  logic                      rf_map_err_i,
    output logic                      data_req_o,
    input  logic                      data_gnt_i,
    output logic [AddressWidth-1:0]   data_addr_o,
    output logic                      data_we_o,
    output logic [DataWidth/8-1:0]    data_be_o,
    output logic [DataWidth-1:0]      data_wdata_o,
    input  logic                      data_rvalid_i,
    input  logic [DataWidth-1:0]      data_rdata_i,
    input  logic                      data_err_i
);

    localparam logic [4:0] LAST_IDX = RV32E ? 5'(CtxDmaLastRegE) : 5'(CtxDmaLastReg);

    ctx_dma_state_e            state, next_state;
    logic                      dir;
    logic [AddressWidth-1:0]   base;
    logic [4:0]                idx;
    logic [DataWidth-1:0]      buffer;
    logic                      err;

    logic                      accept;
    logic                      cap_rf;
    logic                      cap_mem;
    logic                      step;
    logic                      fail;

    logic                      is_last;
    logic [AddressWidth-1:0]   rf_addr;
    logic [AddressWidth-1:0]   mem_addr;

    assign is_last  = (idx == LAST_IDX);
    assign rf_addr  = RfMapBase + (AddressWidth'(idx) << 2);
    assign mem_addr = base + (AddressWidth'(idx) << 2);

    assign rf_map_be_o = '1;
    assign data_be_o   = '1;
    assign err_o       = err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state     = state;
        busy_o         = (state != IDLE);
        done_o         = 1'b0;
        rf_map_req_o   = 1'b0;
        rf_map_addr_o  = '0;
        rf_map_we_o    = 1'b0;
        rf_map_wdata_o = '0;
        data_req_o     = 1'b0;
        data_addr_o    = '0;
        data_we_o      = 1'b0;
        data_wdata_o   = '0;
        accept         = 1'b0;
        cap_rf         = 1'b0;
        cap_mem        = 1'b0;
        step           = 1'b0;
        fail           = 1'b0;

        case (state)
            IDLE: begin
                if (start_i) begin
                    accept     = 1'b1;
                    next_state = dir_i ? MEM_REQ : RF_REQ;
                end
            end
            RF_REQ: begin
                // Register map has no grant: the request is single-cycle.
                rf_map_req_o   = 1'b1;
                rf_map_addr_o  = rf_addr;
                rf_map_we_o    = dir;
                rf_map_wdata_o = dir ? buffer : '0;
                next_state     = RF_WAIT;
            end
            RF_WAIT: begin
                if (rf_map_rvalid_i) begin
                    if (rf_map_err_i) begin
                        fail       = 1'b1;
                        next_state = DONE;
                    end else if (!dir) begin
                        cap_rf     = 1'b1;
                        next_state = MEM_REQ;
                    end else begin
                        step       = 1'b1;
                        next_state = is_last ? DONE : MEM_REQ;
                    end
                end
            end
            MEM_REQ: begin
                data_req_o   = 1'b1;
                data_addr_o  = mem_addr;
                data_we_o    = !dir;
                data_wdata_o = dir ? '0 : buffer;
                if (data_gnt_i) begin
                    next_state = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (data_rvalid_i) begin
                    if (data_err_i) begin
                        fail       = 1'b1;
                        next_state = DONE;
                    end else if (dir) begin
                        cap_mem    = 1'b1;
                        next_state = RF_REQ;
                    end else begin
                        step       = 1'b1;
                        next_state = is_last ? DONE : RF_REQ;
                    end
                end
            end
            DONE: begin
                done_o     = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dir    <= 1'b0;
            base   <= '0;
            idx    <= 5'd0;
            buffer <= '0;
            err    <= 1'b0;
        end else begin
            if (accept) begin
                dir  <= dir_i;
                base <= mem_base_i & ~AddressWidth'(3);
                idx  <= 5'd1;
                err  <= 1'b0;
            end
            if (cap_rf) begin
                buffer <= rf_map_rdata_i;
            end
            if (cap_mem) begin
                buffer <= data_rdata_i;
            end
            if (step && !is_last) begin
                idx <= idx + 5'd1;
            end
            if (fail) begin
                err <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/axum_ctx_dma.md
Name: axum_ctx_dma

Overview:
- Context save/restore engine sitting upstream of the multi-context register file's memory-mapped port.
- Copies the inactive register context to a word-aligned memory buffer (save), or from that buffer back into the context (restore).
- Issues one register access per transfer over the register-map bus and one access on an Ibex-style data bus, so a context switch needs no CPU load/store loop.

Parameters:
- RV32E, 1'b0, when set only x1..x15 are transferred; otherwise x1..x31.
- DataWidth, 32, data width of both buses.
- AddressWidth, 32, address width of both buses.
- RfMapBase, 32'h0, base address of the register-map window; register n is at RfMapBase + 4*n.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- start_i  in  1  one-cycle command strobe
- dir_i  in  1  0 = save (rf->mem), 1 = restore (mem->rf)
- mem_base_i  in  AddressWidth  buffer base; bits [1:0] ignored
- busy_o  out  1  transfer in progress
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  sticky error of last transfer, cleared on accepted start
- rf_map_req_o  out  1  register-map request
- rf_map_addr_o  out  AddressWidth  register-map address
- rf_map_we_o  out  1  register-map write enable
- rf_map_be_o  out  DataWidth/8  byte enables, always all ones
- rf_map_wdata_o  out  DataWidth  register-map write data
- rf_map_rvalid_i  in  1  response valid
- rf_map_rdata_i  in  DataWidth  read data
- rf_map_err_i  in  1  response error
- data_req_o  out  1  memory request
- data_gnt_i  in  1  memory grant
- data_addr_o  out  AddressWidth  memory address
- data_we_o  out  1  memory write enable
- data_be_o  out  DataWidth/8  always all ones
- data_wdata_o  out  DataWidth  memory write data
- data_rvalid_i  in  1  memory response valid
- data_rdata_i  in  DataWidth  memory read data
- data_err_i  in  1  memory response error

Behaviour:
- Clock is clk_i; reset is rst_ni, asynchronous, active-low. Reset forces state IDLE and sets all outputs to 0 (busy_o, done_o, err_o, all req/we/addr/wdata). rf_map_be_o and data_be_o are constant all ones.
- FSM states: IDLE, RF_REQ, RF_WAIT, MEM_REQ, MEM_WAIT, DONE.
- IDLE: start_i latches dir, base {mem_base_i[AW-1:2],2'b00}, idx=1, clears err_o, and moves to RF_REQ (save) or MEM_REQ (restore). busy_o=1 in every non-IDLE state.
- While busy, start_i is ignored.
- RF_REQ: rf_map_req_o=1 for exactly one cycle, with addr=RfMapBase+4*idx. The register-map port accepts every request (no grant). On save, we=0. On restore, we=1 and wdata=buffered word. Next state is RF_WAIT.
- RF_WAIT: wait for rf_map_rvalid_i (nominally the next cycle).
  - On save, capture rdata into the buffer, then go to MEM_REQ.
  - On restore, advance idx.
- MEM_REQ: hold data_req_o with stable addr=base+4*idx, we and wdata until data_gnt_i. Grant in the same cycle as request is legal. Next state is MEM_WAIT.
- MEM_WAIT: wait for data_rvalid_i.
  - On restore, capture rdata into the buffer, then go to RF_REQ.
  - On save, advance idx.
- Advance rule: if idx==last (31, or 15 when RV32E), go to DONE; else idx+1 and start the next transfer in the direction's first state.
- Error: data_err_i or rf_map_err_i with its rvalid sets err_o and jumps to DONE. The remaining registers are not touched.
- DONE: done_o=1 for one cycle, then IDLE.
- At most one outstanding transaction per bus; req is never asserted while a response is pending.
- Address arithmetic wraps modulo 2^AddressWidth.
- Latency: a full save of 31 regs with zero-wait memory (gnt same cycle, rvalid next) takes 31*4+2 = 126 cycles from start to done pulse.
- Reset mid-transfer aborts immediately with no done pulse. Outstanding bus responses after reset are ignored.

Decomposition:
- Add to the shared package: a ctx_dma_state_e enum, and constants CtxDmaLastReg / CtxDmaLastRegE (31/15).
- No sub-module: a single FSM with an index counter and one data buffer register.

Test Plan:
- Save, zero-wait memory, rf read of reg n returns 32'h100+n, base 32'h8000: expect 31 memory writes to 32'h8004..32'h807C with data 32'h101..32'h11F, done_o at cycle 126, err_o=0.
- Restore with gnt delayed 3 cycles, memory word at base+4n = 32'hA0+n: expect 31 rf writes to RfMapBase+4n with data 32'hA0+n, req/addr held stable while ungranted.
- RV32E=1 save: exactly 15 transfers, last memory address base+32'h3C.
- data_err_i on the 5th memory response: err_o=1, done_o pulses, no further requests. A new start clears err_o.
- start_i pulsed while busy and mem_base_i changed: ignored, and the addresses keep the original base. mem_base_i=32'h8003 is treated as 32'h8000.
- rst_ni asserted mid-save at idx=10: outputs 0 immediately, no done_o; a subsequent start restarts from idx=1.
